// File: rtl/result_uart_reporter.sv
// Result reporter: queues {tag, value} words from the core and streams each one
// out as a 6-byte packet (A5, tag, data LSB..MSB) on a UART 8N1 transmit line.
module result_uart_reporter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_LOG2    = 3,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            from_core,
    input  logic [DATA_WIDTH-1:0] from_core_data,
    input  logic                  from_core_valid,
    input  logic                  tx_enable,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  overflow,
    output logic [FIFO_LOG2:0]    fifo_count,
    output logic [15:0]           words_sent
);

    localparam int unsigned DEPTH   = 2 ** FIFO_LOG2;
    localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
    localparam int unsigned CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CLK_W-1:0]   CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_LOG2:0] FULL     = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_t;

    state_t               state_q, state_d;
    logic [CLK_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [2:0]           byte_idx_q, byte_idx_d;
    logic [ENTRY_W-1:0]   pkt_q, pkt_d;
    logic [15:0]          words_q, words_d;

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic                 overflow_q;

    logic push_ok, pop, bit_end;
    logic [7:0] cur_byte;

    // Fullness uses the pre-edge count, so a same-cycle pop never makes room.
    assign push_ok = from_core_valid && (count_q < FULL);
    assign pop     = (state_q == StIdle) && (count_q != '0) && tx_enable;
    assign bit_end = (clk_cnt_q == CLK_LAST);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= {from_core, from_core_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (from_core_valid && !push_ok) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        pkt_d      = pkt_q;
        words_d    = words_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    pkt_d      = mem_q[rd_ptr_q];
                    state_d    = StStart;
                    clk_cnt_d  = '0;
                    byte_idx_d = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q < 3'd5) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = StStart;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            StDone: begin
                words_d = words_q + 16'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            pkt_q      <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            pkt_q      <= pkt_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        case (byte_idx_q)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = {6'b0, pkt_q[ENTRY_W-1 -: 2]};
            3'd2:    cur_byte = pkt_q[7:0];
            3'd3:    cur_byte = pkt_q[15:8];
            3'd4:    cur_byte = pkt_q[23:16];
            default: cur_byte = pkt_q[31:24];
        endcase
    end

    // Decoded straight from state so an async reset forces the line high at once.
    always_comb begin
        case (state_q)
            StStart: uart_tx = 1'b0;
            StData:  uart_tx = cur_byte[bit_idx_q];
            default: uart_tx = 1'b1;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign overflow   = overflow_q;
    assign fifo_count = count_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_result_uart_reporter.sv
// Directed bench for result_uart_reporter: decodes the UART line at mid-bit and
// compares packets, FIFO occupancy, overflow and counters with hand-computed values.
module tb_result_uart_reporter;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  from_core;
    logic [31:0] from_core_data;
    logic        from_core_valid;
    logic        tx_enable;
    logic        uart_tx;
    logic        busy;
    logic        overflow;
    logic [3:0]  fifo_count;
    logic [15:0] words_sent;

    int n_checks = 0;
    int n_errors = 0;

    result_uart_reporter #(
        .DATA_WIDTH  (32),
        .FIFO_LOG2   (3),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .from_core      (from_core),
        .from_core_data (from_core_data),
        .from_core_valid(from_core_valid),
        .tx_enable      (tx_enable),
        .uart_tx        (uart_tx),
        .busy           (busy),
        .overflow       (overflow),
        .fifo_count     (fifo_count),
        .words_sent     (words_sent)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        from_core_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Drives a one-cycle strobe; back-to-back calls give consecutive strobes.
    task automatic push(input logic [1:0] tag, input logic [31:0] d);
        from_core = tag;
        from_core_data = d;
        from_core_valid = 1'b1;
        @(negedge clock);
        from_core_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (uart_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    // Returns at the middle of the stop bit.
    task automatic recv_byte(input string tag, input logic [7:0] exp);
        bit ok;
        logic [7:0] b;
        wait_start(ok);
        check({tag, "_start_seen"}, 32'(ok), 32'd1);
        if (!ok) return;
        repeat (CPB / 2) @(negedge clock);
        check({tag, "_start"}, 32'(uart_tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clock);
            b[k] = uart_tx;
        end
        repeat (CPB) @(negedge clock);
        check({tag, "_stop"}, 32'(uart_tx), 32'd1);
        check(tag, 32'(b), 32'(exp));
    endtask

    task automatic recv_packet(input string tag, input logic [1:0] t, input logic [31:0] d,
                               input bit drop_en);
        logic [7:0] exp [6];
        exp[0] = 8'hA5;
        exp[1] = {6'b0, t};
        exp[2] = d[7:0];
        exp[3] = d[15:8];
        exp[4] = d[23:16];
        exp[5] = d[31:24];
        for (int i = 0; i < 6; i++) begin
            recv_byte($sformatf("%s_b%0d", tag, i), exp[i]);
            if (i == 0 && drop_en) tx_enable = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        bit quiet;
        from_core = '0;
        from_core_data = '0;
        from_core_valid = 1'b0;
        tx_enable = 1'b0;

        // Reset values
        do_reset();
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_words", 32'(words_sent), 32'd0);

        // Single packet, latency and words_sent timing
        tx_enable = 1'b1;
        push(2'd1, 32'h12345678);
        check("t1_tx_before_pop", 32'(uart_tx), 32'd1);
        check("t1_count_pushed", 32'(fifo_count), 32'd1);
        @(negedge clock);
        check("t1_tx_low_after_pop", 32'(uart_tx), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_count_popped", 32'(fifo_count), 32'd0);
        recv_packet("t1", 2'd1, 32'h12345678, 1'b0);
        repeat (CPB / 2) @(negedge clock);
        check("t1_done_words", 32'(words_sent), 32'd0);
        check("t1_done_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("t1_words", 32'(words_sent), 32'd1);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_tx", 32'(uart_tx), 32'd1);

        // Two queued packets: exactly two idle-high cycles between them
        do_reset();
        tx_enable = 1'b0;
        push(2'd2, 32'hDEADBEEF);
        push(2'd3, 32'h01020304);
        tx_enable = 1'b1;
        recv_packet("t5p1", 2'd2, 32'hDEADBEEF, 1'b0);
        gap = 0;
        while (uart_tx !== 1'b0 && gap < 50) begin
            @(negedge clock);
            gap++;
        end
        check("t5_gap", 32'(gap), 32'(CPB / 2 + 2));
        recv_packet("t5p2", 2'd3, 32'h01020304, 1'b0);

        // Nine strobes into a depth-8 FIFO while transmission is held off
        do_reset();
        tx_enable = 1'b0;
        for (int i = 0; i < 9; i++) push(2'(i), 32'hA000_0000 + 32'(i));
        check("t2_count", 32'(fifo_count), 32'd8);
        check("t2_ovf", 32'(overflow), 32'd1);
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) quiet = 1'b0;
        end
        check("t2_line_idle", 32'(quiet), 32'd1);
        tx_enable = 1'b1;
        for (int i = 0; i < 8; i++)
            recv_packet($sformatf("t2p%0d", i), 2'(i), 32'hA000_0000 + 32'(i), 1'b0);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);
        check("t2_count_end", 32'(fifo_count), 32'd0);

        // Push on the pop cycle of a full FIFO is rejected
        do_reset();
        tx_enable = 1'b0;
        for (int i = 0; i < 8; i++) push(2'd0, 32'(i));
        check("t3_ovf_before", 32'(overflow), 32'd0);
        check("t3_count_full", 32'(fifo_count), 32'd8);
        tx_enable = 1'b1;
        push(2'd1, 32'h55555555);
        check("t3_count", 32'(fifo_count), 32'd7);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        tx_enable = 1'b0;

        // Reset during data bit 3 of byte 2 (bit 3 of 0x05 is 0)
        do_reset();
        tx_enable = 1'b1;
        push(2'd2, 32'hCAFEF005);
        push(2'd3, 32'h11112222);
        recv_byte("t4_b0", 8'hA5);
        recv_byte("t4_b1", 8'h02);
        wait_start(quiet);
        check("t4_start_seen", 32'(quiet), 32'd1);
        repeat (4 * CPB + 1) @(negedge clock);
        check("t4_tx_bit3", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        #1;
        check("t4_rst_tx", 32'(uart_tx), 32'd1);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_count", 32'(fifo_count), 32'd0);
        check("t4_rst_ovf", 32'(overflow), 32'd0);
        check("t4_rst_words", 32'(words_sent), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        push(2'd1, 32'h0BADBEEF);
        recv_packet("t4p", 2'd1, 32'h0BADBEEF, 1'b0);

        // Dropping tx_enable mid-packet finishes the packet and starts no more
        do_reset();
        tx_enable = 1'b0;
        push(2'd1, 32'h87654321);
        push(2'd2, 32'h00000001);
        push(2'd3, 32'h00000002);
        tx_enable = 1'b1;
        recv_packet("t6p", 2'd1, 32'h87654321, 1'b1);
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) quiet = 1'b0;
        end
        check("t6_no_start", 32'(quiet), 32'd1);
        check("t6_count", 32'(fifo_count), 32'd2);
        check("t6_words", 32'(words_sent), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
